// File: rtl/mc_controller_pkg.sv
// -----------------------------------------------------------------------------
// mc_controller_pkg
// Shared definitions for the multi-cycle controller and its datapath:
//   - FSM state encoding (state_e)
//   - RV32I major opcode constants
//   - pc_sel, wb_sel and alu_op mux encodings
//   - is_legal_opcode(): the set of opcodes the controller executes
// -----------------------------------------------------------------------------
package mc_controller_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_ALU    = 2'b10;
   localparam logic [1:0] PC_SEL_JAL    = 2'b11;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [1:0] WB_SEL_IMM = 2'b11;

   localparam logic [1:0] ALU_OP_NONE  = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_ADD   = 2'b10;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b11;

   function automatic logic is_legal_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM,
         OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive memory wait cycles and flags a bus timeout.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : controller changed state; restart the count
//   wait_i      : a memory access is pending and mem_ready is low this cycle
//   expired_o   : this wait cycle is the TIMEOUT-th consecutive one
// The count saturates at TIMEOUT and never wraps.
// -----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic wait_i,
   output logic expired_o
);

   localparam int unsigned W     = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
   localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   // Expiry is decided in the wait cycle itself, so a mem_ready in that same
   // cycle (wait_i low) always beats the timeout.
   assign expired_o = wait_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wait_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, rst_n         : clock, async active-low reset
//   opcode, funct3     : instruction fields from the instruction register
//   mem_ready          : shared memory completes the current access
//   branch_taken       : comparator result, valid in EXEC
//   state              : current FSM state (debug)
//   ir_write, pc_write, pc_sel, mem_req, mem_we, mem_addr_sel, mem_size,
//   mem_unsigned, reg_write, alu_op, alu_src, wb_sel : datapath controls
//   illegal, bus_err   : sticky trap causes, cleared only by reset
//   retire             : instruction completes this cycle
// -----------------------------------------------------------------------------
module mc_controller #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic [2:0] state,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic [1:0] mem_size,
   output logic       mem_unsigned,
   output logic       reg_write,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic [1:0] wb_sel,
   output logic       illegal,
   output logic       bus_err,
   output logic       retire
);

   import mc_controller_pkg::*;

   state_e     state_q, state_d;
   logic [6:0] opcode_q;
   logic [2:0] funct3_q;
   logic       illegal_q, illegal_d;
   logic       bus_err_q, bus_err_d;
   logic       size_bad;
   logic       timer_wait;
   logic       timer_expired;

   // Access size 11 has no meaning for loads/stores; it traps instead of
   // reaching the bus.
   assign size_bad   = (funct3_q[1:0] == 2'b11);
   assign timer_wait = !mem_ready &&
                       ((state_q == ST_FETCH) || ((state_q == ST_MEM) && !size_bad));

   mem_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_d != state_q),
      .wait_i    (timer_wait),
      .expired_o (timer_expired)
   );

   assign state   = state_q;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

   // NOTE: every signal written here gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      bus_err_d    = bus_err_q;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = PC_SEL_PLUS4;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 2'b00;
      mem_unsigned = 1'b0;
      reg_write    = 1'b0;
      alu_op       = ALU_OP_NONE;
      alu_src      = 1'b0;
      wb_sel       = WB_SEL_ALU;
      retire       = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               pc_sel   = PC_SEL_PLUS4;
               state_d  = ST_DECODE;
            end else if (timer_expired) begin
               state_d   = ST_TRAP;
               bus_err_d = 1'b1;
            end
         end

         // Legality is judged on the live opcode; it is latched on this edge.
         ST_DECODE: begin
            if (is_legal_opcode(opcode)) begin
               state_d = ST_EXEC;
            end else begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end
         end

         ST_EXEC: begin
            case (opcode_q)
               OPC_OP_IMM: begin alu_op = ALU_OP_FUNCT; alu_src = 1'b1; end
               OPC_OP:     begin alu_op = ALU_OP_FUNCT; alu_src = 1'b0; end
               OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: begin
                  alu_op  = ALU_OP_ADD;
                  alu_src = 1'b1;
               end
               OPC_BRANCH: begin alu_op = ALU_OP_SUB; alu_src = 1'b0; end
               default:    alu_op = ALU_OP_NONE;
            endcase

            if ((opcode_q == OPC_LOAD) || (opcode_q == OPC_STORE)) begin
               state_d = ST_MEM;
            end else if (opcode_q == OPC_BRANCH) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
               if (branch_taken) begin
                  pc_write = 1'b1;
                  pc_sel   = PC_SEL_BRANCH;
               end
            end else begin
               state_d = ST_WB;
            end
         end

         ST_MEM: begin
            if (size_bad) begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end else begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (opcode_q == OPC_STORE);
               mem_size     = funct3_q[1:0];
               mem_unsigned = funct3_q[2];
               if (mem_ready) begin
                  if (opcode_q == OPC_STORE) begin
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_WB;
                  end
               end else if (timer_expired) begin
                  state_d   = ST_TRAP;
                  bus_err_d = 1'b1;
               end
            end
         end

         ST_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
            case (opcode_q)
               OPC_LOAD: wb_sel = WB_SEL_MEM;
               OPC_JAL: begin
                  wb_sel   = WB_SEL_PC4;
                  pc_write = 1'b1;
                  pc_sel   = PC_SEL_JAL;
               end
               OPC_JALR: begin
                  wb_sel   = WB_SEL_PC4;
                  pc_write = 1'b1;
                  pc_sel   = PC_SEL_ALU;
               end
               OPC_LUI: wb_sel = WB_SEL_IMM;
               default: wb_sel = WB_SEL_ALU;
            endcase
         end

         ST_TRAP: ;

         default: state_d = ST_FETCH;
      endcase

      // The register already sits in FETCH while reset is held; the FETCH
      // strobes stay quiet until the reset is released.
      if (!rst_n) begin
         ir_write = 1'b0;
         pc_write = 1'b0;
         mem_req  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         opcode_q  <= '0;
         funct3_q  <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         if (state_q == ST_DECODE) begin
            opcode_q <= opcode;
            funct3_q <= funct3;
         end
      end
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive wait cycles without mem_ready in FETCH or MEM before a bus error is raised.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port opcode, input, 7 bits: instruction bits [6:0] taken from the instruction register.
REQ-005 The block SHALL have port funct3, input, 3 bits: instruction bits [14:12].
REQ-006 The block SHALL have port mem_ready, input, 1 bit: the shared memory completes the current access this cycle.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: the comparator result, valid in EXEC.
REQ-008 The block SHALL have port state, output, 3 bits: the current FSM state, for debug.
REQ-009 The block SHALL have the following control outputs:
- ir_write, pc_write, mem_req, mem_we, mem_addr_sel (0 = pc, 1 = alu), reg_write, illegal, bus_err, retire: 1 bit each.
- pc_sel, 2 bits: 00 pc+4, 01 branch target, 10 alu result, 11 jal target.
- alu_op, 2 bits: 00 none, 01 sub, 10 add, 11 funct-decoded.
- alu_src, 1 bit.
- wb_sel, 2 bits: 00 alu, 01 mem, 10 pc+4, 11 imm.
- mem_size, 2 bits: 00 byte, 01 half, 10 word.
- mem_unsigned, 1 bit.

Function
REQ-010 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=7.
REQ-011 FETCH SHALL behave as follows:
- mem_req=1, mem_addr_sel=0, mem_we=0.
- When mem_ready=1: assert ir_write=1 and pc_write=1 with pc_sel=00 in that same cycle, then go to DECODE.
- Otherwise stay in FETCH.
REQ-012 DECODE SHALL last one cycle and register opcode and funct3 internally; all later states SHALL use only the registered copies.
REQ-013 Transitions out of DECODE SHALL be:
- To EXEC for LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011 and BRANCH 1100011.
- To TRAP for any other opcode.
REQ-014 EXEC SHALL drive alu_op and alu_src as follows:
- OP-IMM: alu_op=11, alu_src=1.
- OP: alu_op=11, alu_src=0.
- LOAD, STORE, JALR and AUIPC: alu_op=10, alu_src=1.
- BRANCH: alu_op=01, alu_src=0.
- LUI and JAL: alu_op=00.
REQ-015 Transitions out of EXEC SHALL be:
- LOAD or STORE: to MEM.
- BRANCH: to FETCH, asserting pc_write=1 and pc_sel=01 only if branch_taken=1, and asserting retire=1.
- All other opcodes: to WB.
REQ-016 MEM SHALL behave as follows:
- mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only.
- mem_size = funct3[1:0]; mem_unsigned = funct3[2].
- On mem_ready: LOAD goes to WB; STORE goes to FETCH with retire=1.
- funct3[1:0]=11 on LOAD or STORE SHALL go to TRAP with illegal=1 instead of issuing mem_req.
REQ-017 WB SHALL behave as follows:
- reg_write=1 and retire=1, then go to FETCH.
- wb_sel: OP-IMM/OP/AUIPC 00; LOAD 01; JAL/JALR 10; LUI 11.
- JAL: pc_write=1 with pc_sel=11. JALR: pc_write=1 with pc_sel=10.
REQ-018 TRAP SHALL hold all strobes at 0 and hold illegal or bus_err at 1 until reset.
REQ-019 A wait counter SHALL count cycles in FETCH or MEM with mem_ready=0:
- It clears on any state change.
- When it reaches MEM_TIMEOUT, the FSM SHALL go to TRAP with bus_err=1.
- If mem_ready=1 in the cycle the limit is reached, mem_ready wins.
REQ-020 The counter width SHALL be $clog2(MEM_TIMEOUT+1) bits and it SHALL never wrap.
REQ-021 All strobes (ir_write, pc_write, mem_req, reg_write, retire) SHALL be Moore/registered-state decodes with no combinational path from mem_ready to mem_req.
REQ-022 With zero wait states, the latency in cycles SHALL be:
- 4 for ALU, LUI, AUIPC, JAL, JALR and STORE.
- 5 for LOAD.
- 3 for BRANCH.

Reset
REQ-023 Asserting rst_n=0 SHALL asynchronously force state=FETCH, clear the wait counter, and clear the latched opcode/funct3, illegal and bus_err.
REQ-024 During reset all outputs SHALL be 0 except mem_req, which SHALL be 0 while rst_n=0 and becomes 1 on the first FETCH cycle after release.
REQ-025 Reset asserted mid-access SHALL abandon the access with no retire.

Structure
REQ-026 The opcode constants, state encodings, and the pc_sel, wb_sel and alu_op encodings SHALL live in a shared package used by the datapath and this block.
REQ-027 The wait/timeout counter SHALL be a sub-module named mem_wait_timer.

Verification
REQ-028 The bench SHALL cover the directed scenarios below.
- ADD, opcode 0110011, mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 and retire=1 in cycle 4 only.
- LW, opcode 0000011 with funct3 010, mem_ready low 3 cycles in MEM -> mem_size=10, WB reached on cycle 8, wb_sel=01.
- BEQ with branch_taken=1, then with branch_taken=0 -> pc_write with pc_sel=01 only in the first case; both return to FETCH after 3 cycles.
- opcode 1111111 -> TRAP after DECODE, illegal=1 held for 10 cycles; rst_n pulse returns to FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> TRAP with bus_err=1 after 16 wait cycles; with mem_ready=1 on the 16th wait cycle -> DECODE instead.
- rst_n dropped mid-MEM on SW -> immediate state=0, mem_we=0, no retire.
